// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC scalar-multiply controller: default width,
// point-at-infinity code, FSM state encoding and point type.
package ecc_pkg;

  localparam int WIDTH = 192;
  localparam logic [WIDTH-1:0] INF_X = '1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SCAN,
    S_DBL_GO,
    S_DBL_WAIT,
    S_BIT,
    S_ADD_GO,
    S_ADD_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
  } point_t;

endpackage

// File: rtl/ecc_scalar_mul_ctrl_if.sv
// Host request/result signals plus double- and add-engine handshakes.
// Signal prefixes are from the controller's point of view (slave modport).
interface ecc_scalar_mul_ctrl_if #(
  parameter int WIDTH = 192
);

  logic             i_start;
  logic [WIDTH-1:0] i_k;
  logic [WIDTH-1:0] i_px;
  logic [WIDTH-1:0] i_py;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_qx;
  logic [WIDTH-1:0] o_qy;

  logic             o_dbl_start;
  logic [WIDTH-1:0] o_dbl_x;
  logic [WIDTH-1:0] o_dbl_y;
  logic             i_dbl_done;
  logic [WIDTH-1:0] i_dbl_x;
  logic [WIDTH-1:0] i_dbl_y;

  logic             o_add_start;
  logic [WIDTH-1:0] o_add_x1;
  logic [WIDTH-1:0] o_add_y1;
  logic [WIDTH-1:0] o_add_x2;
  logic [WIDTH-1:0] o_add_y2;
  logic             i_add_done;
  logic [WIDTH-1:0] i_add_x;
  logic [WIDTH-1:0] i_add_y;

  modport slave (
    input  i_start, i_k, i_px, i_py,
    output o_busy, o_done, o_qx, o_qy,
    output o_dbl_start, o_dbl_x, o_dbl_y,
    input  i_dbl_done, i_dbl_x, i_dbl_y,
    output o_add_start, o_add_x1, o_add_y1, o_add_x2, o_add_y2,
    input  i_add_done, i_add_x, i_add_y
  );

  modport master (
    output i_start, i_k, i_px, i_py,
    input  o_busy, o_done, o_qx, o_qy,
    input  o_dbl_start, o_dbl_x, o_dbl_y,
    output i_dbl_done, i_dbl_x, i_dbl_y,
    input  o_add_start, o_add_x1, o_add_y1, o_add_x2, o_add_y2,
    output i_add_done, i_add_x, i_add_y
  );

endinterface

// File: rtl/ecc_point_cmp.sv
// Combinational accumulator-vs-base-point comparison used by the scan FSM.
module ecc_point_cmp #(
  parameter int WIDTH = 192
) (
  input  logic [WIDTH-1:0] i_ax,
  input  logic [WIDTH-1:0] i_ay,
  input  logic [WIDTH-1:0] i_px,
  input  logic [WIDTH-1:0] i_py,
  output logic             o_acc_inf,
  output logic             o_p_inf,
  output logic             o_x_eq,
  output logic             o_y_eq
);

  // Infinity is any point whose x is all ones; y is don't-care.
  assign o_acc_inf = &i_ax;
  assign o_p_inf   = &i_px;
  assign o_x_eq    = (i_ax == i_px);
  assign o_y_eq    = (i_ay == i_py);

endmodule

// File: rtl/ecc_scalar_mul_ctrl.sv
// Double-and-add sequencer computing Q = k*P, scalar scanned MSB-first.
// Optional build macro ECC_LEAD_ZERO_SKIP_EN skips leading zero bits in SCAN.
module ecc_scalar_mul_ctrl #(
  parameter int WIDTH = ecc_pkg::WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic i_clk,
  input  logic i_rst,
  ecc_scalar_mul_ctrl_if.slave bus
);
  import ecc_pkg::*;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
  } pt_t;

  localparam logic [WIDTH-1:0] INF_CODE = '1;
  localparam logic [CNT_W-1:0] IDX_TOP  = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  pt_t              r_acc;
  pt_t              r_p;
  pt_t              r_q;
  pt_t              r_dbl_op;
  pt_t              r_add_op;
  logic [WIDTH-1:0] r_k;
  logic [CNT_W-1:0] r_idx;
  logic             r_dbl_only;
  logic             r_busy;
  logic             r_done;
  logic             r_dbl_start;
  logic             r_add_start;

  logic             w_acc_inf;
  logic             w_p_inf;
  logic             w_x_eq;
  logic             w_y_eq;
  logic             w_kbit;

  ecc_point_cmp #(.WIDTH(WIDTH)) u_cmp (
    .i_ax      (r_acc.x),
    .i_ay      (r_acc.y),
    .i_px      (r_p.x),
    .i_py      (r_p.y),
    .o_acc_inf (w_acc_inf),
    .o_p_inf   (w_p_inf),
    .o_x_eq    (w_x_eq),
    .o_y_eq    (w_y_eq)
  );

  assign w_kbit = r_k[r_idx];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.i_start) w_next = S_SCAN;
      end
      S_SCAN: begin
        if (r_k == '0 || w_p_inf) begin
          w_next = S_DONE;
        end else begin
`ifdef ECC_LEAD_ZERO_SKIP_EN
          if (w_kbit) w_next = S_NEXT;
`else
          w_next = S_DBL_GO;
`endif
        end
      end
      S_DBL_GO: begin
        w_next = w_acc_inf ? S_BIT : S_DBL_WAIT;
      end
      S_DBL_WAIT: begin
        if (bus.i_dbl_done) w_next = r_dbl_only ? S_NEXT : S_BIT;
      end
      S_BIT: begin
        // acc == P cannot go through the add engine; it is a doubling instead.
        if (!w_kbit || w_acc_inf || (w_x_eq && !w_y_eq)) w_next = S_NEXT;
        else if (w_x_eq)                                  w_next = S_DBL_GO;
        else                                              w_next = S_ADD_GO;
      end
      S_ADD_GO: begin
        w_next = S_ADD_WAIT;
      end
      S_ADD_WAIT: begin
        if (bus.i_add_done) w_next = S_NEXT;
      end
      S_NEXT: begin
        w_next = (r_idx == '0) ? S_DONE : S_DBL_GO;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc       <= '{x: INF_CODE, y: '0};
      r_p         <= '0;
      r_q         <= '0;
      r_dbl_op    <= '0;
      r_add_op    <= '0;
      r_k         <= '0;
      r_idx       <= IDX_TOP;
      r_dbl_only  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbl_start <= 1'b0;
      r_add_start <= 1'b0;
    end else begin
      r_dbl_start <= 1'b0;
      r_add_start <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_k        <= bus.i_k;
            r_p        <= '{x: bus.i_px, y: bus.i_py};
            r_acc      <= '{x: INF_CODE, y: '0};
            r_idx      <= IDX_TOP;
            r_dbl_only <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
`ifdef ECC_LEAD_ZERO_SKIP_EN
        S_SCAN: begin
          if (r_k != '0 && !w_p_inf) begin
            if (w_kbit) r_acc <= r_p;
            else        r_idx <= r_idx - 1'b1;
          end
        end
`endif
        S_DBL_GO: begin
          if (!w_acc_inf) begin
            r_dbl_start <= 1'b1;
            r_dbl_op    <= r_acc;
          end
        end
        S_DBL_WAIT: begin
          if (bus.i_dbl_done) r_acc <= '{x: bus.i_dbl_x, y: bus.i_dbl_y};
        end
        S_BIT: begin
          if (w_kbit) begin
            if (w_acc_inf)                r_acc      <= r_p;
            else if (w_x_eq && !w_y_eq)   r_acc      <= '{x: INF_CODE, y: '0};
            else if (w_x_eq)              r_dbl_only <= 1'b1;
          end
        end
        S_ADD_GO: begin
          r_add_start <= 1'b1;
          r_add_op    <= r_acc;
        end
        S_ADD_WAIT: begin
          if (bus.i_add_done) r_acc <= '{x: bus.i_add_x, y: bus.i_add_y};
        end
        S_NEXT: begin
          r_dbl_only <= 1'b0;
          if (r_idx != '0) r_idx <= r_idx - 1'b1;
        end
        S_DONE: begin
          r_q    <= r_acc;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_qx        = r_q.x;
  assign bus.o_qy        = r_q.y;
  assign bus.o_dbl_start = r_dbl_start;
  assign bus.o_dbl_x     = r_dbl_op.x;
  assign bus.o_dbl_y     = r_dbl_op.y;
  assign bus.o_add_start = r_add_start;
  assign bus.o_add_x1    = r_add_op.x;
  assign bus.o_add_y1    = r_add_op.y;
  // P is latched for the whole operation, so it doubles as the held second operand.
  assign bus.o_add_x2    = r_p.x;
  assign bus.o_add_y2    = r_p.y;

endmodule

// File: tb/tb_ecc_scalar_mul_ctrl.sv
// Bench for ecc_scalar_mul_ctrl over an 8-bit toy curve y^2 = x^3 + 2x + 2 mod 17.
module tb_ecc_scalar_mul_ctrl;

  localparam int W  = 8;
  localparam int PM = 17;
  localparam logic [W-1:0]   INF   = 8'hFF;
  localparam logic [2*W-1:0] PBASE = {8'd5, 8'd1};
  localparam logic [2*W-1:0] QINF  = {8'hFF, 8'h00};
  localparam int LIMIT = 400;

  logic i_clk = 1'b0;
  logic i_rst;

  ecc_scalar_mul_ctrl_if #(.WIDTH(W)) bus();

  ecc_scalar_mul_ctrl #(.WIDTH(W)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int dbl_cnt = 0;
  int add_cnt = 0;
  int fixed_lat = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int md(input int v);
    return ((v % PM) + PM) % PM;
  endfunction

  function automatic int inv(input int v);
    for (int i = 1; i < PM; i++) if (md(v * i) == 1) return i;
    return 0;
  endfunction

  // Group law on {x,y}; x == 0xFF is the point at infinity.
  function automatic logic [2*W-1:0] padd(input logic [2*W-1:0] a, input logic [2*W-1:0] b);
    int ax, ay, bx, by, lam, x3, y3;
    ax = int'(a[15:8]); ay = int'(a[7:0]);
    bx = int'(b[15:8]); by = int'(b[7:0]);
    if (a[15:8] == INF) return b;
    if (b[15:8] == INF) return a;
    if (ax == bx) begin
      if (md(ay + by) == 0) return QINF;
      lam = md((3 * ax * ax + 2) * inv(md(2 * ay)));
    end else begin
      lam = md((by - ay) * inv(md(bx - ax)));
    end
    x3 = md(lam * lam - ax - bx);
    y3 = md(lam * (ax - x3) - ay);
    return {8'(x3), 8'(y3)};
  endfunction

  function automatic logic [2*W-1:0] ref_mul(input int k, input logic [2*W-1:0] p);
    logic [2*W-1:0] r;
    r = QINF;
    repeat (k) r = padd(r, p);
    return r;
  endfunction

  initial begin : dbl_engine
    logic [2*W-1:0] op;
    int lat;
    bit abort;
    bus.i_dbl_done = 1'b0; bus.i_dbl_x = '0; bus.i_dbl_y = '0;
    forever begin
      @(negedge i_clk);
      if (bus.o_dbl_start && !i_rst) begin
        dbl_cnt++;
        op = {bus.o_dbl_x, bus.o_dbl_y};
        lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 20));
        abort = 1'b0;
        for (int c = 1; c < lat; c++) begin
          @(negedge i_clk);
          if (i_rst) begin abort = 1'b1; break; end
          check("dbl_hold", {bus.o_dbl_x, bus.o_dbl_y}, op);
        end
        if (!abort) begin
          {bus.i_dbl_x, bus.i_dbl_y} = padd(op, op);
          bus.i_dbl_done = 1'b1;
          @(negedge i_clk);
          bus.i_dbl_done = 1'b0;
        end
      end
    end
  end

  initial begin : add_engine
    logic [4*W-1:0] op;
    int lat;
    bit abort;
    bus.i_add_done = 1'b0; bus.i_add_x = '0; bus.i_add_y = '0;
    forever begin
      @(negedge i_clk);
      if (bus.o_add_start && !i_rst) begin
        add_cnt++;
        op = {bus.o_add_x1, bus.o_add_y1, bus.o_add_x2, bus.o_add_y2};
        check("add_xdiff", 32'(op[31:24] != op[15:8]), 32'd1);
        lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 20));
        abort = 1'b0;
        for (int c = 1; c < lat; c++) begin
          @(negedge i_clk);
          if (i_rst) begin abort = 1'b1; break; end
          check("add_hold", {bus.o_add_x1, bus.o_add_y1, bus.o_add_x2, bus.o_add_y2}, op);
        end
        if (!abort) begin
          {bus.i_add_x, bus.i_add_y} = padd(op[31:16], op[15:0]);
          bus.i_add_done = 1'b1;
          @(negedge i_clk);
          bus.i_add_done = 1'b0;
        end
      end
    end
  end

  task automatic run_op(input logic [W-1:0] k, input logic [2*W-1:0] pt, input bit poke,
                        output logic [2*W-1:0] q, output int cyc);
    @(negedge i_clk);
    dbl_cnt = 0; add_cnt = 0;
    bus.i_k = k; {bus.i_px, bus.i_py} = pt; bus.i_start = 1'b1;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    cyc = 1;
    check("busy_rise", 32'(bus.o_busy), 32'd1);
    while (!bus.o_done && cyc < LIMIT) begin
      if (poke && cyc == 4) begin
        bus.i_start = 1'b1; bus.i_k = ~k; bus.i_px = 8'd6; bus.i_py = 8'd3;
      end else begin
        bus.i_start = 1'b0;
      end
      @(negedge i_clk);
      cyc++;
    end
    bus.i_start = 1'b0;
    check("done_seen", 32'(bus.o_done), 32'd1);
    check("busy_fall", 32'(bus.o_busy), 32'd0);
    q = {bus.o_qx, bus.o_qy};
    @(negedge i_clk);
    check("done_pulse", 32'(bus.o_done), 32'd0);
    check("q_held", {bus.o_qx, bus.o_qy}, q);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [2*W-1:0] q, base;
    int cyc, k, m;
    i_rst = 1'b1;
    bus.i_start = 1'b0; bus.i_k = '0; bus.i_px = '0; bus.i_py = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_q", {bus.o_qx, bus.o_qy}, 32'd0);
    check("rst_ctl", {bus.o_busy, bus.o_done, bus.o_dbl_start, bus.o_add_start}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    run_op(8'd1, PBASE, 1'b0, q, cyc);
    check("k1_q", q, {8'd5, 8'd1});
    check("k1_noadd", add_cnt, 0);
`ifdef ECC_LEAD_ZERO_SKIP_EN
    check("k1_fast", 32'(cyc <= 12), 32'd1);
`else
    check("k1_slow", 32'(cyc >= 20), 32'd1);
`endif
    run_op(8'd2, PBASE, 1'b0, q, cyc);
    check("k2_q", q, {8'd6, 8'd3});
    run_op(8'd3, PBASE, 1'b0, q, cyc);
    check("k3_q", q, {8'd10, 8'd6});
    run_op(8'd18, PBASE, 1'b0, q, cyc);
    check("k18_q", q, {8'd5, 8'd16});
    run_op(8'd19, PBASE, 1'b0, q, cyc);
    check("k19_inf", q, QINF);
    run_op(8'd21, PBASE, 1'b0, q, cyc);
    check("k21_acc_eq_p", q, {8'd6, 8'd3});
    run_op(8'd0, PBASE, 1'b0, q, cyc);
    check("k0_inf", q, QINF);
    check("k0_lat", 32'(cyc <= 3), 32'd1);
    check("k0_noeng", dbl_cnt + add_cnt, 0);
    run_op(8'd5, QINF, 1'b0, q, cyc);
    check("pinf_q", q, QINF);

    run_op(8'd3, PBASE, 1'b1, q, cyc);
    check("busy_start_ignored", q, {8'd10, 8'd6});

    // Reset while the double engine is still working.
    fixed_lat = 20;
    @(negedge i_clk);
    bus.i_k = 8'd2; {bus.i_px, bus.i_py} = PBASE; bus.i_start = 1'b1;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    for (int c = 0; c < 40 && !bus.o_dbl_start; c++) @(negedge i_clk);
    check("rst_dbl_seen", 32'(bus.o_dbl_start), 32'd1);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    check("midrst_busy", 32'(bus.o_busy), 32'd0);
    check("midrst_dbl", 32'(bus.o_dbl_start), 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    fixed_lat = 0;
    run_op(8'd3, PBASE, 1'b0, q, cyc);
    check("after_rst_q", q, {8'd10, 8'd6});

    for (int n = 0; n < 25; n++) begin
      m = int'($urandom_range(0, 18));
      base = ref_mul(m, PBASE);
      k = int'($urandom_range(0, 255));
      run_op(8'(k), base, 1'b0, q, cyc);
      check("rand_q", q, ref_mul(k, base));
      check("rand_lat", 32'(cyc <= W * 44 + 4), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
